aplic_src_gateway: RTL

APLIC_SRC_GATEWAY -- requirements
Module: aplic_src_gateway

---
 rtl/aplic_src_gateway.sv | 123 ++++++++++++
 1 files changed

// File: rtl/aplic_src_gateway.sv
// APLIC interrupt source gateway.
// Each source goes through a private synchronizer and is rectified by its mode.
// A per-source pending bit is then maintained as a latched edge, a level
// follower, or a software-only bit. No state is shared between sources.
module aplic_src_gateway #(
  parameter int unsigned NR_SRC      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   ni_rst,
  input  logic [NR_SRC-1:0]      i_irq_sources,
  input  logic [NR_SRC-1:0][2:0] i_sourcecfg,
  input  logic [NR_SRC-1:0]      i_cfg_we,
  input  logic [NR_SRC-1:0]      i_setip,
  input  logic [NR_SRC-1:0]      i_clrip,
  input  logic [NR_SRC-1:0]      i_claim,
  output logic [NR_SRC-1:0]      o_rectified,
  output logic [NR_SRC-1:0]      o_pending
);

  // Source modes. Codes 2 and 3 are reserved and fall into the inactive branch.
  localparam logic [2:0] MODE_INACTIVE = 3'd0;
  localparam logic [2:0] MODE_DETACHED = 3'd1;
  localparam logic [2:0] MODE_EDGE1    = 3'd4;
  localparam logic [2:0] MODE_EDGE0    = 3'd5;
  localparam logic [2:0] MODE_LEVEL1   = 3'd6;
  localparam logic [2:0] MODE_LEVEL0   = 3'd7;

  // Reject illegal parameterisations at elaboration.
  if ((NR_SRC < 1) || (NR_SRC > 1023)) begin : g_bad_nr_src
    $fatal(1, "aplic_src_gateway: NR_SRC must be in 1..1023");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync_stages
    $fatal(1, "aplic_src_gateway: SYNC_STAGES must be in 2..4");
  end

  logic [NR_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NR_SRC-1:0] sync_last;
  logic [NR_SRC-1:0] rect;
  logic [NR_SRC-1:0] prev_q;
  logic [NR_SRC-1:0] edge_det;
  logic [NR_SRC-1:0] pend_q;
  logic [NR_SRC-1:0] pend_d;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: stage 0 samples the raw wires, the last stage feeds logic.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= i_irq_sources;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Rectify by mode and detect rising edges of the rectified value.
  // Only modes 4..7 (bit 2 set) look at the wire; bit 0 selects inversion,
  // so Edge0/Level0 read as 1 while the synchronizer holds reset zeros.
  // A config write masks the edge so the old prev value never pairs with
  // the new mode's rectified value.
  always_comb begin
    rect     = '0;
    edge_det = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      rect[i]     = i_sourcecfg[i][2] & (sync_last[i] ^ i_sourcecfg[i][0]);
      edge_det[i] = rect[i] & ~prev_q[i] & ~i_cfg_we[i];
    end
  end

  // Next pending value per source. In the set/clear modes, set wins over clear
  // so a coincident edge or software set is never lost.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NR_SRC; i++) begin
      case (i_sourcecfg[i])
        MODE_DETACHED: begin
          pend_d[i] = i_setip[i] | (pend_q[i] & ~(i_clrip[i] | i_claim[i]));
        end
        MODE_EDGE1, MODE_EDGE0: begin
          pend_d[i] = edge_det[i] | i_setip[i] |
                      (pend_q[i] & ~(i_clrip[i] | i_claim[i]));
        end
        MODE_LEVEL1, MODE_LEVEL0: begin
          pend_d[i] = rect[i] & ~i_claim[i];
        end
        MODE_INACTIVE: begin
          pend_d[i] = 1'b0;
        end
        default: begin
          pend_d[i] = 1'b0;
        end
      endcase
    end
  end

  // prev tracks the rectified value under the current mode, including in a
  // write cycle, so the following cycle compares against the new mode.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= rect;
    end
  end

  // Pending register.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign o_rectified = rect;
  assign o_pending   = pend_q;

endmodule
